// File: rtl/vec_dot_job_scheduler.sv
// vec_dot_job_scheduler: queues dot-product jobs from the HPS, launches them
// one at a time on the vector dot-product core, and buffers the 64-bit
// results for software readback with an optional level interrupt.
module vec_dot_job_scheduler #(
  parameter int JOB_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        core_start,
  output logic [31:0] core_length,
  output logic [31:0] core_vecA_baseAddr,
  output logic [31:0] core_vecB_baseAddr,
  input  logic        core_busy,
  input  logic [63:0] core_result,
  output logic        irq
);

  localparam int JAW = $clog2(JOB_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam logic [JAW:0] JOB_FULL_COUNT = (JAW+1)'(JOB_DEPTH);
  localparam logic [RAW:0] RES_FULL_COUNT = (RAW+1)'(RES_DEPTH);

  localparam logic [2:0] ADDR_ARG_LEN  = 3'd0;
  localparam logic [2:0] ADDR_ARG_A    = 3'd1;
  localparam logic [2:0] ADDR_ARG_B    = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_RES_LO   = 3'd4;
  localparam logic [2:0] ADDR_RES_HI   = 3'd5;
  localparam logic [2:0] ADDR_CTRL     = 3'd6;
  localparam logic [2:0] ADDR_DONE_CNT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Staged job arguments, combined with the ARG_B write data on push
  logic [31:0] arg_len;
  logic [31:0] arg_a;

  // Job FIFO
  logic [31:0]  job_len_mem [JOB_DEPTH];
  logic [31:0]  job_a_mem   [JOB_DEPTH];
  logic [31:0]  job_b_mem   [JOB_DEPTH];
  logic [JAW-1:0] job_wr_ptr;
  logic [JAW-1:0] job_rd_ptr;
  logic [JAW:0]   job_count;
  logic           job_full;
  logic           job_empty;
  logic           job_push;
  logic           job_pop;

  // Result FIFO
  logic [63:0]    res_mem [RES_DEPTH];
  logic [RAW-1:0] res_wr_ptr;
  logic [RAW-1:0] res_rd_ptr;
  logic [RAW:0]   res_count;
  logic           res_full;
  logic           res_empty;
  logic           res_push;
  logic           res_pop;

  // Control and status
  logic        ovf;
  logic        irq_en;
  logic [31:0] done_cnt;
  logic [31:0] status_word;
  logic [31:0] read_value;

  // Register-map strobes
  logic wr_len;
  logic wr_a;
  logic wr_b;
  logic wr_ctrl;
  logic rd_hi;

  assign wr_len  = avs_write && (avs_address == ADDR_ARG_LEN);
  assign wr_a    = avs_write && (avs_address == ADDR_ARG_A);
  assign wr_b    = avs_write && (avs_address == ADDR_ARG_B);
  assign wr_ctrl = avs_write && (avs_address == ADDR_CTRL);
  assign rd_hi   = avs_read  && (avs_address == ADDR_RES_HI);

  assign job_full  = (job_count == JOB_FULL_COUNT);
  assign job_empty = (job_count == '0);
  assign res_full  = (res_count == RES_FULL_COUNT);
  assign res_empty = (res_count == '0);

  // A job pushed into a full FIFO is dropped; a pop of an empty result FIFO is ignored
  assign job_push = wr_b && !job_full;
  assign res_pop  = rd_hi && !res_empty;

  // FSM state register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state, launch pulse and FIFO pop/push requests
  always_comb begin
    next_state = state;
    core_start = 1'b0;
    job_pop    = 1'b0;
    res_push   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!job_empty && !res_full) begin
          job_pop    = 1'b1;
          next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (core_busy) begin
          next_state = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!core_busy) begin
          res_push   = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Argument staging registers written by software
  always_ff @(posedge clock) begin
    if (!resetn) begin
      arg_len <= '0;
      arg_a   <= '0;
    end else begin
      if (wr_len) begin
        arg_len <= avs_writedata;
      end
      if (wr_a) begin
        arg_a <= avs_writedata;
      end
    end
  end

  // Job FIFO storage; contents need no reset because the pointers guard them
  always_ff @(posedge clock) begin
    if (job_push) begin
      job_len_mem[job_wr_ptr] <= arg_len;
      job_a_mem[job_wr_ptr]   <= arg_a;
      job_b_mem[job_wr_ptr]   <= avs_writedata;
    end
  end

  // Job FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!resetn) begin
      job_wr_ptr <= '0;
      job_rd_ptr <= '0;
      job_count  <= '0;
    end else begin
      if (job_push) begin
        job_wr_ptr <= job_wr_ptr + 1'b1;
      end
      if (job_pop) begin
        job_rd_ptr <= job_rd_ptr + 1'b1;
      end
      case ({job_push, job_pop})
        2'b10:   job_count <= job_count + 1'b1;
        2'b01:   job_count <= job_count - 1'b1;
        default: job_count <= job_count;
      endcase
    end
  end

  // Core argument registers, loaded on pop and held until the next pop
  always_ff @(posedge clock) begin
    if (!resetn) begin
      core_length        <= '0;
      core_vecA_baseAddr <= '0;
      core_vecB_baseAddr <= '0;
    end else if (job_pop) begin
      core_length        <= job_len_mem[job_rd_ptr];
      core_vecA_baseAddr <= job_a_mem[job_rd_ptr];
      core_vecB_baseAddr <= job_b_mem[job_rd_ptr];
    end
  end

  // Result FIFO storage; a slot is reserved at launch so the push never overflows
  always_ff @(posedge clock) begin
    if (res_push) begin
      res_mem[res_wr_ptr] <= core_result;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!resetn) begin
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_count  <= '0;
    end else begin
      if (res_push) begin
        res_wr_ptr <= res_wr_ptr + 1'b1;
      end
      if (res_pop) begin
        res_rd_ptr <= res_rd_ptr + 1'b1;
      end
      case ({res_push, res_pop})
        2'b10:   res_count <= res_count + 1'b1;
        2'b01:   res_count <= res_count - 1'b1;
        default: res_count <= res_count;
      endcase
    end
  end

  // Sticky overflow flag and interrupt enable
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ovf    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (wr_b && job_full) begin
        ovf <= 1'b1;
      end else if (wr_ctrl && avs_writedata[0]) begin
        ovf <= 1'b0;
      end
      if (wr_ctrl) begin
        irq_en <= avs_writedata[1];
      end
    end
  end

  // Completed-job counter, wraps naturally
  always_ff @(posedge clock) begin
    if (!resetn) begin
      done_cnt <= '0;
    end else if (res_push) begin
      done_cnt <= done_cnt + 32'd1;
    end
  end

  // Status word assembly
  always_comb begin
    status_word        = '0;
    status_word[0]     = job_full;
    status_word[1]     = job_empty;
    status_word[2]     = res_empty;
    status_word[3]     = res_full;
    status_word[4]     = ovf;
    status_word[5]     = (state != S_IDLE);
    status_word[11:8]  = 4'(job_count);
    status_word[19:16] = 4'(res_count);
  end

  // Read mux; write-only and unlisted addresses read as zero
  always_comb begin
    read_value = '0;
    case (avs_address)
      ADDR_STATUS: begin
        read_value = status_word;
      end
      ADDR_RES_LO: begin
        if (!res_empty) begin
          read_value = res_mem[res_rd_ptr][31:0];
        end
      end
      ADDR_RES_HI: begin
        if (!res_empty) begin
          read_value = res_mem[res_rd_ptr][63:32];
        end
      end
      ADDR_DONE_CNT: begin
        read_value = done_cnt;
      end
      default: begin
        read_value = '0;
      end
    endcase
  end

  // Registered read data with one cycle of latency
  always_ff @(posedge clock) begin
    if (!resetn) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= read_value;
    end
  end

  // Registered level interrupt while results are waiting
  always_ff @(posedge clock) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && !res_empty;
    end
  end

endmodule

// File: tb/tb_vec_dot_job_scheduler.sv
// Testbench for vec_dot_job_scheduler: a behavioural core with its own SDRAM
// image, a queue-based scheduler model checked every cycle, and directed
// tests with hand-computed literal expectations.
module tb_vec_dot_job_scheduler;

  localparam int JOB_DEPTH = 4;
  localparam int RES_DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        core_start;
  logic [31:0] core_length;
  logic [31:0] core_vecA_baseAddr;
  logic [31:0] core_vecB_baseAddr;
  logic        core_busy = 1'b0;
  logic [63:0] core_result = '0;
  logic        irq;

  int assertCount = 0;
  int failCount = 0;

  vec_dot_job_scheduler #(
    .JOB_DEPTH(JOB_DEPTH),
    .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .avs_address(avs_address),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .core_start(core_start),
    .core_length(core_length),
    .core_vecA_baseAddr(core_vecA_baseAddr),
    .core_vecB_baseAddr(core_vecB_baseAddr),
    .core_busy(core_busy),
    .core_result(core_result),
    .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // SDRAM image and dot product over signed 32-bit words
  logic [31:0] mem [0:255];

  function automatic logic [63:0] dotProduct(input logic [31:0] len, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] acc;
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    int ia;
    int ib;
    acc = '0;
    for (int i = 0; i < int'(len); i++) begin
      ia = (int'(a >> 2) + i) & 255;
      ib = (int'(b >> 2) + i) & 255;
      pa = 64'($signed(mem[ia]));
      pb = 64'($signed(mem[ib]));
      acc = acc + pa * pb;
    end
    return acc;
  endfunction

  // Behavioural core: busy the cycle after start, for coreLat+1 cycles
  int coreLat = 4;
  int coreCnt = 0;
  logic [63:0] coreNext = '0;

  always @(posedge clock) begin
    if (!resetn) begin
      core_busy   <= 1'b0;
      core_result <= '0;
      coreCnt     <= 0;
    end else if (core_busy) begin
      if (coreCnt == 0) begin
        core_busy   <= 1'b0;
        core_result <= coreNext;
      end else begin
        coreCnt <= coreCnt - 1;
      end
    end else if (core_start) begin
      core_busy <= 1'b1;
      coreCnt   <= coreLat;
      coreNext  <= dotProduct(core_length, core_vecA_baseAddr, core_vecB_baseAddr);
    end
  end

  // Scheduler model: queues of accepted jobs and finished results
  typedef struct {
    logic [31:0] len;
    logic [31:0] a;
    logic [31:0] b;
  } job_t;

  job_t        jobQ[$];
  logic [63:0] resQ[$];
  logic [31:0] mLen = '0;
  logic [31:0] mA = '0;
  logic        mOvf = 1'b0;
  logic        mIrqEn = 1'b0;
  logic        mInflight = 1'b0;
  logic        mSeenBusy = 1'b0;
  logic [63:0] mInflightRes = '0;
  logic [31:0] mDone = '0;
  logic        expIrq = 1'b0;
  logic        expIrqNext;
  logic        prevStart = 1'b0;
  logic        rdPending = 1'b0;
  logic [31:0] expRd = '0;
  logic [31:0] mStatus;
  job_t        headJob;

  // Compare process: checks DUT outputs against the model on every falling edge
  always @(negedge clock) begin
    if (rdPending) begin
      checkOutput("readdata", avs_readdata, expRd);
      rdPending = 1'b0;
    end
    checkOutput("irq", irq, expIrq);
    if (!resetn) begin
      jobQ.delete();
      resQ.delete();
      mLen = '0;
      mA = '0;
      mOvf = 1'b0;
      mIrqEn = 1'b0;
      mInflight = 1'b0;
      mSeenBusy = 1'b0;
      mDone = '0;
      expIrq = 1'b0;
      prevStart = 1'b0;
    end else begin
      if (core_start) begin
        checkOutput("start_while_busy", core_busy, 0);
        checkOutput("start_back_to_back", prevStart, 0);
        checkOutput("start_has_job", jobQ.size() != 0, 1);
        if (jobQ.size() != 0) begin
          headJob = jobQ.pop_front();
          checkOutput("core_length", core_length, headJob.len);
          checkOutput("core_vecA", core_vecA_baseAddr, headJob.a);
          checkOutput("core_vecB", core_vecB_baseAddr, headJob.b);
          mInflightRes = dotProduct(headJob.len, headJob.a, headJob.b);
          mInflight = 1'b1;
          mSeenBusy = 1'b0;
        end
      end
      expIrqNext = mIrqEn && (resQ.size() != 0);
      if (avs_read) begin
        mStatus = '0;
        mStatus[0] = (jobQ.size() == JOB_DEPTH);
        mStatus[1] = (jobQ.size() == 0);
        mStatus[2] = (resQ.size() == 0);
        mStatus[3] = (resQ.size() == RES_DEPTH);
        mStatus[4] = mOvf;
        mStatus[5] = mInflight;
        mStatus[11:8] = 4'(jobQ.size());
        mStatus[19:16] = 4'(resQ.size());
        case (avs_address)
          3'd3: expRd = mStatus;
          3'd4: expRd = (resQ.size() != 0) ? resQ[0][31:0] : 32'd0;
          3'd5: begin
            if (resQ.size() != 0) begin
              expRd = resQ[0][63:32];
              void'(resQ.pop_front());
            end else begin
              expRd = 32'd0;
            end
          end
          3'd7: expRd = mDone;
          default: expRd = 32'd0;
        endcase
        rdPending = 1'b1;
      end
      if (avs_write) begin
        case (avs_address)
          3'd0: mLen = avs_writedata;
          3'd1: mA = avs_writedata;
          3'd2: begin
            if (jobQ.size() < JOB_DEPTH) begin
              jobQ.push_back('{len: mLen, a: mA, b: avs_writedata});
            end else begin
              mOvf = 1'b1;
            end
          end
          3'd6: begin
            if (avs_writedata[0]) mOvf = 1'b0;
            mIrqEn = avs_writedata[1];
          end
          default: ;
        endcase
      end
      if (mInflight) begin
        if (core_busy) begin
          mSeenBusy = 1'b1;
        end else if (mSeenBusy) begin
          resQ.push_back(mInflightRes);
          mDone = mDone + 32'd1;
          mInflight = 1'b0;
          mSeenBusy = 1'b0;
        end
      end
      expIrq = expIrqNext;
      prevStart = core_start;
    end
  end

  // Bus tasks: entered and left just after a rising edge
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    avs_address = addr;
    avs_writedata = data;
    avs_write = 1'b1;
    @(posedge clock);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read = 1'b1;
    @(posedge clock);
    #1;
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic submitJob(input logic [31:0] len, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(3'd0, len);
    applyStimulus(3'd1, a);
    applyStimulus(3'd2, b);
  endtask

  task automatic waitResults(input int n, input int budget);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < budget; i++) begin
      readReg(3'd3, d);
      if (int'(d[19:16]) >= n) break;
    end
    checkOutput("result_ready", int'(d[19:16]) >= n, 1);
  endtask

  task automatic readResult(input string name, input logic [63:0] expv);
    logic [31:0] lo;
    logic [31:0] hi;
    waitResults(1, 400);
    readReg(3'd4, lo);
    readReg(3'd5, hi);
    checkOutput(name, {hi, lo}, expv);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);
    for (int i = 0; i < 8; i++) mem[64 + i] = 32'(i + 4);
    mem[32] = 32'hFFFF_FFFE;
    mem[33] = 32'd3;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    readReg(3'd3, d);
    checkOutput("reset_status", d, 32'h6);
    readReg(3'd7, d);
    checkOutput("reset_done_cnt", d, 0);
    checkOutput("reset_irq", irq, 0);

    // Single job: launch timing and result 1*4+2*5+3*6
    $display("[TB] single job");
    coreLat = 4;
    submitJob(32'd3, 32'h0, 32'h100);
    checkOutput("start_t1", core_start, 0);
    idle(1);
    checkOutput("start_t2", core_start, 1);
    checkOutput("len_t2", core_length, 3);
    checkOutput("vecB_t2", core_vecB_baseAddr, 32'h100);
    idle(1);
    checkOutput("start_t3", core_start, 0);
    waitResults(1, 100);
    readReg(3'd4, d);
    checkOutput("single_res_lo", d, 32);
    readReg(3'd5, d);
    checkOutput("single_res_hi", d, 0);
    readReg(3'd3, d);
    checkOutput("single_status", d, 32'h6);
    readReg(3'd7, d);
    checkOutput("single_done_cnt", d, 1);

    // Overflow: one job in flight, four queued, sixth dropped
    $display("[TB] job fifo overflow");
    coreLat = 40;
    applyStimulus(3'd0, 32'd1);
    applyStimulus(3'd1, 32'h0);
    for (int k = 0; k < 6; k++) applyStimulus(3'd2, 32'h100 + 32'(4 * k));
    readReg(3'd3, d);
    checkOutput("ovf_status", d, 32'h435);
    applyStimulus(3'd6, 32'h1);
    readReg(3'd3, d);
    checkOutput("ovf_cleared", d[4], 0);
    for (int k = 0; k < 5; k++) readResult("ovf_result", 64'(4 + k));
    readReg(3'd7, d);
    checkOutput("ovf_done_cnt", d, 6);
    readReg(3'd3, d);
    checkOutput("ovf_drained", d, 32'h6);

    // Result backpressure with interrupt enabled
    $display("[TB] result backpressure");
    coreLat = 2;
    applyStimulus(3'd6, 32'h2);
    for (int k = 0; k < 6; k++) begin
      submitJob(32'd2, 32'h0, 32'h100 + 32'(4 * k));
      idle(8);
    end
    idle(10);
    readReg(3'd3, d);
    checkOutput("bp_status", d, 32'h40208);
    checkOutput("bp_irq", irq, 1);
    readReg(3'd4, d);
    checkOutput("bp_first_lo", d, 14);
    readReg(3'd5, d);
    checkOutput("bp_first_hi", d, 0);
    idle(20);
    readReg(3'd3, d);
    checkOutput("bp_relaunch_status", d, 32'h40108);
    for (int k = 1; k < 6; k++) readResult("bp_result", 64'(14 + 3 * k));
    readReg(3'd7, d);
    checkOutput("bp_done_cnt", d, 12);
    applyStimulus(3'd6, 32'h0);
    idle(2);
    checkOutput("bp_irq_off", irq, 0);

    // Signed operands and zero-length job
    $display("[TB] signed and zero length");
    coreLat = 3;
    submitJob(32'd1, 32'h80, 32'h84);
    readResult("neg_result", 64'hFFFF_FFFF_FFFF_FFFA);
    submitJob(32'd0, 32'h0, 32'h0);
    readResult("zero_len_result", 64'h0);
    readReg(3'd7, d);
    checkOutput("zero_len_done_cnt", d, 14);

    // Reset while the core is busy
    $display("[TB] reset mid-job");
    coreLat = 30;
    submitJob(32'd2, 32'h0, 32'h100);
    for (int i = 0; i < 20; i++) begin
      if (core_busy) break;
      idle(1);
    end
    checkOutput("busy_seen", core_busy, 1);
    idle(3);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    checkOutput("rst_core_start", core_start, 0);
    readReg(3'd3, d);
    checkOutput("rst_status", d, 32'h6);
    readReg(3'd7, d);
    checkOutput("rst_done_cnt", d, 0);
    idle(40);
    readReg(3'd3, d);
    checkOutput("rst_status_late", d, 32'h6);
    checkOutput("rst_irq", irq, 0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
